irq_entry_sequencer: RTL
========================

// Module: irq_entry_sequencer
// PURPOSE
//  Sequences 65C02 interrupt/reset entry for the core control unit.
//  - Synchronises resb-qualified nmib/irqb pins; latches NMI on edge, qualifies IRQ with the I flag.
//  - Arbitrates RES > NMI > IRQ > BRK at instruction boundaries.
//  - Drives the 7-step entry: force BRK, dummy read, push PCH/PCL/P, fetch vector lo/hi.
//  - Sits between the pin-level interrupt prioritiser and the stack/address datapath.
// PARAMETERS
//  SYNC_STAGES  2        flops in the nmib/irqb synchronisers (>=2)
//  RES_VEC      16'hFFFC reset vector low-byte address
//  NMI_VEC      16'hFFFA NMI vector low-byte address
//  IRQ_VEC      16'hFFFE IRQ/BRK vector low-byte address
// PORTS
//  clk       in   1   core clock, rising edge
//  resb      in   1   reset: one clock; reset is asynchronous and active-low
//  nmib_in   in   1   NMI pin, asynchronous, active-low
//  irqb_in   in   1   IRQ pin, asynchronous, active-low, level
//  i_flag    in   1   current P.I
//  sync      in   1   opcode-fetch cycle (instruction boundary)
//  brk_op    in   1   fetched opcode is BRK, valid with sync
//  rdy       in   1   0 = stall: all state and outputs frozen
//  int_take  out  1   1-cycle: replace fetched opcode with forced BRK (NMI/IRQ)
//  seq_busy  out  1   entry or reset sequence in progress
//  seq_step  out  3   current step 0..6
//  push_en   out  1   stack write this cycle (steps 2..4, not reset)
//  push_sel  out  2   00 PCH, 01 PCL, 10 P
//  b_flag    out  1   B bit for pushed P (1 only for BRK)
//  set_i     out  1   set P.I and clear P.D (step 4)
//  vec_rd    out  1   vector read this cycle (steps 5,6)
//  vec_addr  out  16  vector byte address
//  nmi_ack   out  1   1-cycle: NMI vector committed, pending cleared
// BEHAVIOUR
//  Reset: sync flops = 1, nmi_pend = 0, state RST step 0.
//  - While resb low: outputs 0 except seq_busy = 1, vec_addr = RES_VEC.
//  - Reset mid-sequence aborts immediately; no partial push completes.
//  States: IDLE, ENTRY, RST. Step counter advances only when rdy = 1.
//  RST: after resb rises, 7 steps as ENTRY.
//  - push_en is held 0 (dummy stack reads); set_i fires at step 4.
//  - Vector is RES_VEC/+1; then IDLE.
//  NMI edge: nmi_pend sets on synchronised 1->0.
//  - Held-low pin does not re-set after clear.
//  - A new edge in the nmi_ack cycle re-sets it (set wins over clear).
//  IDLE, on sync & rdy, priority NMI(nmi_pend) > IRQ(~irqb_s & ~i_flag) > BRK(brk_op).
//  - NMI/IRQ: int_take = 1 that cycle; ENTRY step 0.
//  - BRK: ENTRY step 0, b_flag = 1 for the sequence; int_take = 0.
//  ENTRY steps:
//  - 0 forced opcode
//  - 1 dummy operand
//  - 2/3/4 push PCH/PCL/P, with set_i at 4
//  - 5 vec_rd at base
//  - 6 vec_rd at base+1
//  - then IDLE: seq_busy = 0 the cycle after step 6
//  Vector base is latched at step 4 (hijack):
//  - NMI if nmi_pend, else RES_VEC (RST), else IRQ_VEC.
//  - An IRQ/BRK sequence hijacked by NMI keeps its b_flag but vectors to NMI.
//  nmi_ack pulses at step 5 iff base = NMI_VEC; nmi_pend clears on it.
//  IRQ deasserted after the boundary sample does not cancel the sequence.
//  Latency: pin edge -> eligible at the first sync >= SYNC_STAGES+1 clocks later.
// CONFIGURATION
//  WAI_SUPPORT_EN defined:
//  - Adds wai_op (in, 1; valid with sync) and wai_halt (out, 1; reset 0).
//  - wai_op at sync & rdy enters WAIT: wai_halt = 1.
//  - WAIT exits on nmi_pend or ~irqb_s, regardless of i_flag.
//  - On exit, the entry sequence runs if the source is allowed; else IDLE, resume without vectoring.
//  - wai_halt drops the cycle after exit.
//  WAI_SUPPORT_EN undefined: no WAIT state; wai_op/wai_halt ports absent.
// TESTING
//  1 resb low 5 clk, release -> 7 steps, push_en never 1, vec_addr FFFC then FFFD, seq_busy 0 after.
//  2 irqb_in low, i_flag=0, sync -> int_take 1; pushes PCH,PCL,P (b_flag 0); vec_addr FFFE/FFFF; set_i at step 4.
//  3 irqb_in low, i_flag=1, brk_op at sync -> BRK entry, b_flag 1, vector FFFE, int_take 0.
//  4 nmib_in falls during IRQ step 2 -> vector FFFA/FFFB; nmi_ack at step 5; pin held low -> no second NMI.
//  5 rdy low for 3 clk at step 3 -> seq_step, push_en, vec_addr held; sequence resumes with no skipped step.
//  6 (WAI_SUPPORT_EN) wai_op, i_flag=1, irqb_in low -> wai_halt 0 after exit, IDLE, no vec_rd.

Source files
------------

// File: rtl/irq_entry_sequencer_if.sv
// -----------------------------------------------------------------------------
// irq_entry_sequencer_if
// Purpose : bundles the control-unit side signals of the 65C02 interrupt/reset
//           entry sequencer.
// Modports:
//   master - control unit / pin side: drives nmib_in, irqb_in, i_flag, sync,
//            brk_op, rdy (and wai_op); observes the sequencer outputs.
//   slave  - the sequencer: observes the inputs; drives int_take, seq_busy,
//            seq_step, push_en, push_sel, b_flag, set_i, vec_rd, vec_addr,
//            nmi_ack (and wai_halt).
// Build option: WAI_SUPPORT_EN adds wai_op / wai_halt.
// -----------------------------------------------------------------------------
interface irq_entry_sequencer_if;
    logic        nmib_in;
    logic        irqb_in;
    logic        i_flag;
    logic        sync;
    logic        brk_op;
    logic        rdy;
    logic        int_take;
    logic        seq_busy;
    logic [2:0]  seq_step;
    logic        push_en;
    logic [1:0]  push_sel;
    logic        b_flag;
    logic        set_i;
    logic        vec_rd;
    logic [15:0] vec_addr;
    logic        nmi_ack;
`ifdef WAI_SUPPORT_EN
    logic        wai_op;
    logic        wai_halt;

    modport master (
        output nmib_in, irqb_in, i_flag, sync, brk_op, rdy, wai_op,
        input  int_take, seq_busy, seq_step, push_en, push_sel, b_flag,
               set_i, vec_rd, vec_addr, nmi_ack, wai_halt
    );
    modport slave (
        input  nmib_in, irqb_in, i_flag, sync, brk_op, rdy, wai_op,
        output int_take, seq_busy, seq_step, push_en, push_sel, b_flag,
               set_i, vec_rd, vec_addr, nmi_ack, wai_halt
    );
`else
    modport master (
        output nmib_in, irqb_in, i_flag, sync, brk_op, rdy,
        input  int_take, seq_busy, seq_step, push_en, push_sel, b_flag,
               set_i, vec_rd, vec_addr, nmi_ack
    );
    modport slave (
        input  nmib_in, irqb_in, i_flag, sync, brk_op, rdy,
        output int_take, seq_busy, seq_step, push_en, push_sel, b_flag,
               set_i, vec_rd, vec_addr, nmi_ack
    );
`endif
endinterface

// File: rtl/irq_entry_sequencer.sv
// -----------------------------------------------------------------------------
// irq_entry_sequencer
// Purpose : sequences 65C02 interrupt / reset entry. Synchronises the nmib and
//           irqb pins, latches NMI on a falling edge, arbitrates
//           RES > NMI > IRQ > BRK at instruction boundaries and walks the
//           7-step entry (forced opcode, dummy, push PCH/PCL/P, vector lo/hi).
// Ports   :
//   clk  - core clock, rising edge
//   resb - asynchronous active-low reset
//   bus  - irq_entry_sequencer_if.slave (pins, flags, sequencing outputs)
// Build option: WAI_SUPPORT_EN adds a WAIT state (wai_op in, wai_halt out).
// -----------------------------------------------------------------------------
module irq_entry_sequencer #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [15:0] RES_VEC     = 16'hFFFC,
    parameter logic [15:0] NMI_VEC     = 16'hFFFA,
    parameter logic [15:0] IRQ_VEC     = 16'hFFFE
) (
    input  logic                  clk,
    input  logic                  resb,
    irq_entry_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ENTRY = 2'd1,
        ST_RST   = 2'd2
`ifdef WAI_SUPPORT_EN
        ,ST_WAIT = 2'd3
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  step_q, step_d;
    logic        b_q, b_d;
    logic [15:0] base_q, base_d;
    logic        nmi_pend_q, nmi_pend_d;
    logic [SYNC_STAGES-1:0] nmi_sync_q, nmi_sync_d;
    logic [SYNC_STAGES-1:0] irq_sync_q, irq_sync_d;

    logic irqb_s;
    logic nmi_fall;
    logic irq_ok;
    logic in_seq;
    logic ack;
    logic take;

    // Synchroniser chains: stage 0 samples the pin, each later stage the one before.
    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign nmi_sync_d[gi] = bus.nmib_in;
                assign irq_sync_d[gi] = bus.irqb_in;
            end else begin : g_next
                assign nmi_sync_d[gi] = nmi_sync_q[gi-1];
                assign irq_sync_d[gi] = irq_sync_q[gi-1];
            end
        end
    endgenerate

    assign irqb_s = irq_sync_q[SYNC_STAGES-1];
    // Falling edge detected as it enters the last stage, so nmi_pend becomes
    // visible in the same cycle as the synchronised level would.
    assign nmi_fall = nmi_sync_q[SYNC_STAGES-1] & ~nmi_sync_q[SYNC_STAGES-2];
    assign irq_ok   = ~irqb_s & ~bus.i_flag;
    assign in_seq   = (state_q == ST_ENTRY) || (state_q == ST_RST);
    assign ack      = in_seq && (step_q == 3'd5) && (base_q == NMI_VEC);

    always_ff @(posedge clk or negedge resb) begin
        if (!resb) begin
            state_q    <= ST_RST;
            step_q     <= 3'd0;
            b_q        <= 1'b0;
            base_q     <= RES_VEC;
            nmi_pend_q <= 1'b0;
            nmi_sync_q <= '1;
            irq_sync_q <= '1;
        end else if (bus.rdy) begin
            state_q    <= state_d;
            step_q     <= step_d;
            b_q        <= b_d;
            base_q     <= base_d;
            nmi_pend_q <= nmi_pend_d;
            nmi_sync_q <= nmi_sync_d;
            irq_sync_q <= irq_sync_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        b_d        = b_q;
        base_d     = base_q;
        take       = 1'b0;
        // A new edge in the acknowledge cycle must win over the clear.
        nmi_pend_d = nmi_fall | (nmi_pend_q & ~ack);

        case (state_q)
            ST_IDLE: begin
                if (bus.sync) begin
                    if (nmi_pend_q || irq_ok) begin
                        take    = bus.rdy;
                        state_d = ST_ENTRY;
                        step_d  = 3'd0;
                        b_d     = 1'b0;
                    end else if (bus.brk_op) begin
                        state_d = ST_ENTRY;
                        step_d  = 3'd0;
                        b_d     = 1'b1;
                    end
`ifdef WAI_SUPPORT_EN
                    else if (bus.wai_op) begin
                        state_d = ST_WAIT;
                    end
`endif
                end
            end
            ST_ENTRY, ST_RST: begin
                // Vector base is decided late so an NMI can hijack the sequence.
                if (step_q == 3'd4) begin
                    if (nmi_pend_q)
                        base_d = NMI_VEC;
                    else if (state_q == ST_RST)
                        base_d = RES_VEC;
                    else
                        base_d = IRQ_VEC;
                end
                if (step_q == 3'd6) begin
                    state_d = ST_IDLE;
                    step_d  = 3'd0;
                end else begin
                    step_d  = step_q + 3'd1;
                end
            end
`ifdef WAI_SUPPORT_EN
            ST_WAIT: begin
                // Any pending source wakes the core; vectoring only if allowed.
                if (nmi_pend_q || !irqb_s) begin
                    if (nmi_pend_q || irq_ok) begin
                        state_d = ST_ENTRY;
                        step_d  = 3'd0;
                        b_d     = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.int_take = take;
    assign bus.seq_busy = in_seq;
    assign bus.seq_step = step_q;
    assign bus.push_en  = (state_q == ST_ENTRY) && (step_q >= 3'd2) && (step_q <= 3'd4);
    assign bus.push_sel = !bus.push_en     ? 2'b00 :
                          (step_q == 3'd3) ? 2'b01 :
                          (step_q == 3'd4) ? 2'b10 : 2'b00;
    assign bus.b_flag   = (state_q == ST_ENTRY) && b_q;
    assign bus.set_i    = in_seq && (step_q == 3'd4);
    assign bus.vec_rd   = in_seq && (step_q >= 3'd5);
    assign bus.vec_addr = base_q + {15'd0, (in_seq && (step_q == 3'd6))};
    assign bus.nmi_ack  = ack;
`ifdef WAI_SUPPORT_EN
    assign bus.wai_halt = (state_q == ST_WAIT);
`endif

endmodule
